// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Op encodings, FSM state type and helpers for the mult/div unit.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int unsigned DWIDTH_DEF = 32;
    localparam int unsigned CNT_W      = $clog2(DWIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One iteration of shift-add multiply or restoring divide.
// Revision : 1.0
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic [2*DWIDTH-1:0] i_acc,
    input  logic [DWIDTH-1:0]   i_opnd,
    input  logic [1:0]          i_op,
    output logic [2*DWIDTH-1:0] o_acc
);

    logic [DWIDTH-1:0] w_addend;
    logic [DWIDTH:0]   w_sum;
    logic [DWIDTH:0]   w_rem_sh;
    logic [DWIDTH-1:0] w_rem_sub;
    logic [DWIDTH-1:0] w_rem_new;
    logic              w_ge;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    // The restored remainder is always below the divisor, so a DWIDTH-bit subtract suffices.
    always_comb begin
        w_addend  = i_acc[0] ? i_opnd : '0;
        w_sum     = {1'b0, i_acc[2*DWIDTH-1:DWIDTH]} + {1'b0, w_addend};
        w_rem_sh  = {i_acc[2*DWIDTH-1:DWIDTH], i_acc[DWIDTH-1]};
        w_ge      = (w_rem_sh >= {1'b0, i_opnd});
        w_rem_sub = w_rem_sh[DWIDTH-1:0] - i_opnd;
        w_rem_new = w_ge ? w_rem_sub : w_rem_sh[DWIDTH-1:0];
        if (op_is_div(i_op)) begin
            o_acc = {w_rem_new, i_acc[DWIDTH-2:0], w_ge};
        end else begin
            o_acc = {w_sum, i_acc[DWIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative multiply/divide unit with private HI/LO and ID stall.
// Revision : 1.0
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DWIDTH-1:0] rs_data_i,
    input  logic [DWIDTH-1:0] rt_data_i,
    input  logic              hilo_rd_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic [DWIDTH-1:0] hi_o,
    output logic [DWIDTH-1:0] lo_o
);

    localparam int unsigned         c_cnt_w = $clog2(DWIDTH);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DWIDTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [2*DWIDTH-1:0] r_acc;
    logic [2*DWIDTH-1:0] w_acc_nxt;
    logic [2*DWIDTH-1:0] w_prod;
    logic [DWIDTH-1:0]   r_opnd;
    logic [DWIDTH-1:0]   r_hi;
    logic [DWIDTH-1:0]   r_lo;
    logic [DWIDTH-1:0]   w_hi_fix;
    logic [DWIDTH-1:0]   w_lo_fix;
    logic [DWIDTH-1:0]   w_abs_a;
    logic [DWIDTH-1:0]   w_abs_b;
    logic [1:0]          r_op;
    logic                r_sign_a;
    logic                r_sign_b;
    logic                r_div0;
    logic                w_sign_a;
    logic                w_sign_b;
    logic                w_accept;

    assign w_accept = start_i & ~flush_i & ~busy_o;
    assign w_sign_a = op_is_signed(op_i) & rs_data_i[DWIDTH-1];
    assign w_sign_b = op_is_signed(op_i) & rt_data_i[DWIDTH-1];
    // -2^(DWIDTH-1) negates to itself, which is already its correct unsigned magnitude.
    assign w_abs_a  = w_sign_a ? -rs_data_i : rs_data_i;
    assign w_abs_b  = w_sign_b ? -rt_data_i : rt_data_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CALC;
            CALC:    if (r_cnt == c_last) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (r_state != IDLE);
        stall_o = busy_o & (start_i | hilo_rd_i) & ~flush_i;
    end

    muldiv_step #(
        .DWIDTH (DWIDTH)
    ) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_op   (r_op),
        .o_acc  (w_acc_nxt)
    );

    // Divide by zero leaves the remainder equal to |A|, so HI recovers raw A through the sign fix.
    always_comb begin
        w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
        if (op_is_div(r_op)) begin
            w_lo_fix = r_div0 ? '1 :
                       ((r_sign_a ^ r_sign_b) ? -r_acc[DWIDTH-1:0] : r_acc[DWIDTH-1:0]);
            w_hi_fix = r_sign_a ? -r_acc[2*DWIDTH-1:DWIDTH] : r_acc[2*DWIDTH-1:DWIDTH];
        end else begin
            w_hi_fix = w_prod[2*DWIDTH-1:DWIDTH];
            w_lo_fix = w_prod[DWIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= op_i;
                        r_sign_a <= w_sign_a;
                        r_sign_b <= w_sign_b;
                        r_cnt    <= '0;
                        r_div0   <= op_is_div(op_i) & (rt_data_i == '0);
                        if (op_is_div(op_i)) begin
                            r_acc  <= {{DWIDTH{1'b0}}, w_abs_a};
                            r_opnd <= w_abs_b;
                        end else begin
                            r_acc  <= {{DWIDTH{1'b0}}, w_abs_b};
                            r_opnd <= w_abs_a;
                        end
                    end
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
                FIX: begin
                    r_hi <= w_hi_fix;
                    r_lo <= w_lo_fix;
                end
                default: ;
            endcase
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire
